mux_select_sequencer: RTL and testbench

- Upstream driver for the 16-to-1 selector stage.
- Accepts a 16-bit word over a valid/ready handshake and registers it.
- Generates the 4-bit select sequence that steps through all 16 positions, presenting one bit per accepted output beat (w_reg[sel]), with backpressure, frame markers and a completed-word counter.
- Acts as the parallel-to-serial front end for the lab-6 datapath; the w and sel outputs can drive a 16:1 selector directly.

---
 rtl/mux_select_sequencer.sv | 101 ++++++++++
 tb/tb_mux_select_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// Purpose: registers a 16-bit word and walks a 4-bit select across it, one serial bit per beat.
// Latency: bit START is presented with out_valid the cycle after accept; 16 beats per word, no bubble between words.
// Backpressure: with out_ready low, sel, w and f hold; a new word is only taken in idle or on the last beat.
module mux_select_sequencer #(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      w,
    output logic [3:0]       sel,
    output logic             f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             first,
    output logic             last,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    localparam logic [3:0] START   = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [3:0] END_IDX = MSB_FIRST ? 4'd0  : 4'd15;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      w_nxt;
    logic [3:0]       sel_nxt;
    logic [CNT_W-1:0] words_done_nxt;
    logic             accept;
    logic             beat;

    // out_valid is a pure function of the state register, so in_valid never reaches it combinationally
    assign out_valid = (state == SHIFT);
    assign busy      = out_valid;
    assign f         = w[sel];
    assign first     = out_valid & (sel == START);
    assign last      = out_valid & (sel == END_IDX);
    assign beat      = out_valid & out_ready;
    assign in_ready  = (state == IDLE) | (beat & last);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state      <= IDLE;
            w          <= 16'h0000;
            sel        <= START;
            words_done <= '0;
        end else begin
            state      <= state_nxt;
            w          <= w_nxt;
            sel        <= sel_nxt;
            words_done <= words_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        w_nxt          = w;
        sel_nxt        = sel;
        words_done_nxt = words_done;
        case (state)
            IDLE: begin
                if (accept) begin
                    w_nxt     = in_data;
                    sel_nxt   = START;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (last) begin
                        words_done_nxt = words_done + {{(CNT_W-1){1'b0}}, 1'b1};
                        sel_nxt        = START;
                        // a word waiting on the last beat is loaded directly, keeping the stream contiguous
                        if (accept) begin
                            w_nxt = in_data;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        sel_nxt = sel - 4'd1;
                    end else begin
                        sel_nxt = sel + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = START;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: LSB-first and MSB-first instances share clock and reset.
module tb_mux_select_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;

    logic [15:0] in_data0, in_data1;
    logic        in_valid0, in_valid1, out_ready0, out_ready1;
    logic        in_ready0, in_ready1;
    logic [15:0] w0, w1;
    logic [3:0]  sel0, sel1;
    logic        f0, f1, out_valid0, out_valid1;
    logic        first0, first1, last0, last1, busy0, busy1;
    logic [7:0]  words_done0, words_done1;

    int checks   = 0;
    int failures = 0;

    // f sequence of 16'hA5C3 sent LSB first
    int exp_seq [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    always #5 Clock = ~Clock;

    mux_select_sequencer #(.MSB_FIRST(1'b0), .CNT_W(8)) dut0 (
        .Clock(Clock), .Resetn(Resetn), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .w(w0), .sel(sel0), .f(f0), .out_valid(out_valid0),
        .out_ready(out_ready0), .first(first0), .last(last0), .busy(busy0),
        .words_done(words_done0)
    );

    mux_select_sequencer #(.MSB_FIRST(1'b1), .CNT_W(8)) dut1 (
        .Clock(Clock), .Resetn(Resetn), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .w(w1), .sel(sel1), .f(f1), .out_valid(out_valid1),
        .out_ready(out_ready1), .first(first1), .last(last1), .busy(busy1),
        .words_done(words_done1)
    );

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (2) @(posedge Clock);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            if (c == 1) Resetn = 1'b1;
            #1;
            checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid c=%0d got=%b exp=0", c, out_valid0); end
            checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready c=%0d got=%b exp=1", c, in_ready0); end
            checks++; if (sel0 !== 4'd0) begin failures++; $display("FAIL reset_sel c=%0d got=%0d exp=0", c, sel0); end
            checks++; if (w0 !== 16'h0000) begin failures++; $display("FAIL reset_w c=%0d got=%h exp=0000", c, w0); end
            checks++; if (words_done0 !== 8'd0) begin failures++; $display("FAIL reset_words_done c=%0d got=%0d exp=0", c, words_done0); end
            checks++; if (sel1 !== 4'd15) begin failures++; $display("FAIL reset_sel_msb c=%0d got=%0d exp=15", c, sel1); end
        end
    endtask

    task automatic test_single_word();
        @(negedge Clock);
        in_data0 = 16'hA5C3; in_valid0 = 1'b1; out_ready0 = 1'b1;
        @(negedge Clock);
        in_valid0 = 1'b0; in_data0 = 16'h0000;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid0 !== 1'b1 || busy0 !== 1'b1) begin failures++; $display("FAIL single_valid beat=%0d got=%b/%b exp=1/1", i, out_valid0, busy0); end
            checks++; if (f0 !== exp_seq[i][0]) begin failures++; $display("FAIL single_f beat=%0d got=%b exp=%0d", i, f0, exp_seq[i]); end
            checks++; if (sel0 !== 4'(i)) begin failures++; $display("FAIL single_sel beat=%0d got=%0d exp=%0d", i, sel0, i); end
            checks++; if (first0 !== (i == 0)) begin failures++; $display("FAIL single_first beat=%0d got=%b", i, first0); end
            checks++; if (last0 !== (i == 15)) begin failures++; $display("FAIL single_last beat=%0d got=%b", i, last0); end
            checks++; if (w0 !== 16'hA5C3) begin failures++; $display("FAIL single_w beat=%0d got=%h exp=a5c3", i, w0); end
            @(negedge Clock); #1;
        end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", out_valid0); end
        checks++; if (words_done0 !== 8'd1) begin failures++; $display("FAIL single_words_done got=%0d exp=1", words_done0); end
    endtask

    task automatic test_backpressure();
        int idx, stall, cycles;
        @(negedge Clock);
        in_data0 = 16'hA5C3; in_valid0 = 1'b1; out_ready0 = 1'b1;
        @(negedge Clock);
        in_valid0 = 1'b0;
        idx = 0; stall = 0; cycles = 0;
        while (out_valid0 && cycles < 40) begin
            if (idx == 5 && stall < 3) begin
                out_ready0 = 1'b0;
                #1;
                checks++; if (sel0 !== 4'd5 || f0 !== 1'b0 || out_valid0 !== 1'b1) begin failures++; $display("FAIL bp_hold stall=%0d got sel=%0d f=%b v=%b exp sel=5 f=0 v=1", stall, sel0, f0, out_valid0); end
                stall++;
            end else begin
                out_ready0 = 1'b1;
                #1;
                checks++; if (idx > 15 || f0 !== exp_seq[idx][0] || sel0 !== 4'(idx)) begin failures++; $display("FAIL bp_beat idx=%0d got f=%b sel=%0d", idx, f0, sel0); end
                idx++;
            end
            cycles++;
            @(negedge Clock);
        end
        out_ready0 = 1'b1;
        #1;
        checks++; if (idx !== 16) begin failures++; $display("FAIL bp_beats got=%0d exp=16", idx); end
        checks++; if (cycles !== 19) begin failures++; $display("FAIL bp_cycles got=%0d exp=19", cycles); end
        checks++; if (words_done0 !== 8'd2) begin failures++; $display("FAIL bp_words_done got=%0d exp=2", words_done0); end
    endtask

    task automatic test_back_to_back();
        @(negedge Clock);
        in_data0 = 16'hFFFF; in_valid0 = 1'b1; out_ready0 = 1'b1;
        @(negedge Clock);
        in_data0 = 16'h0001;
        #1;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) in_valid0 = 1'b0;
            checks++; if (out_valid0 !== 1'b1) begin failures++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, out_valid0); end
            checks++; if (f0 !== ((i < 16) || (i == 16))) begin failures++; $display("FAIL b2b_f beat=%0d got=%b", i, f0); end
            checks++; if (in_ready0 !== ((i == 15) || (i == 31))) begin failures++; $display("FAIL b2b_in_ready beat=%0d got=%b", i, in_ready0); end
            @(negedge Clock); #1;
        end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL b2b_drop got=%b exp=0", out_valid0); end
        checks++; if (words_done0 !== 8'd4) begin failures++; $display("FAIL b2b_words_done got=%0d exp=4", words_done0); end
    endtask

    task automatic test_msb_first();
        @(negedge Clock);
        in_data1 = 16'h8001; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge Clock);
        in_valid1 = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (sel1 !== 4'(15 - i)) begin failures++; $display("FAIL msb_sel beat=%0d got=%0d exp=%0d", i, sel1, 15 - i); end
            checks++; if (f1 !== ((i == 0) || (i == 15))) begin failures++; $display("FAIL msb_f beat=%0d got=%b", i, f1); end
            checks++; if (first1 !== (i == 0) || last1 !== (i == 15)) begin failures++; $display("FAIL msb_marks beat=%0d got first=%b last=%b", i, first1, last1); end
            @(negedge Clock); #1;
        end
        checks++; if (out_valid1 !== 1'b0 || words_done1 !== 8'd1) begin failures++; $display("FAIL msb_end got v=%b words=%0d exp v=0 words=1", out_valid1, words_done1); end
    endtask

    task automatic test_mid_word_reset();
        @(negedge Clock);
        in_data0 = 16'hA5C3; in_valid0 = 1'b1; out_ready0 = 1'b1;
        @(negedge Clock);
        in_valid0 = 1'b0;
        repeat (7) @(negedge Clock);
        #1;
        checks++; if (sel0 !== 4'd7 || out_valid0 !== 1'b1) begin failures++; $display("FAIL mid_pre got sel=%0d v=%b exp sel=7 v=1", sel0, out_valid0); end
        Resetn = 1'b0;
        @(negedge Clock); #1;
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid0); end
        checks++; if (words_done0 !== 8'd0) begin failures++; $display("FAIL mid_words_done got=%0d exp=0", words_done0); end
        checks++; if (sel0 !== 4'd0 || w0 !== 16'h0000) begin failures++; $display("FAIL mid_regs got sel=%0d w=%h exp 0/0000", sel0, w0); end
        Resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock); #1;
            checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin failures++; $display("FAIL mid_no_resume c=%0d got v=%b rdy=%b", c, out_valid0, in_ready0); end
        end
    endtask

    task automatic test_counter_wrap();
        int lasts, cyc;
        @(negedge Clock);
        in_data0 = 16'h5A5A; in_valid0 = 1'b1; out_ready0 = 1'b1;
        lasts = 0; cyc = 0;
        while (lasts < 256 && cyc < 5000) begin
            @(negedge Clock); #1;
            cyc++;
            if (out_valid0 && last0) begin
                lasts++;
                if (lasts == 128) begin
                    checks++; if (words_done0 !== 8'd127) begin failures++; $display("FAIL wrap_mid got=%0d exp=127", words_done0); end
                end
                if (lasts == 256) begin
                    checks++; if (words_done0 !== 8'd255) begin failures++; $display("FAIL wrap_pre got=%0d exp=255", words_done0); end
                    in_valid0 = 1'b0;
                end
            end
        end
        checks++; if (cyc !== 4096) begin failures++; $display("FAIL wrap_cycles got=%0d exp=4096", cyc); end
        @(negedge Clock); #1;
        checks++; if (words_done0 !== 8'd0) begin failures++; $display("FAIL wrap_words_done got=%0d exp=0", words_done0); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL wrap_drop got=%b exp=0", out_valid0); end
    endtask

    initial begin
        in_data0 = 16'h0000; in_valid0 = 1'b0; out_ready0 = 1'b1;
        in_data1 = 16'h0000; in_valid1 = 1'b0; out_ready1 = 1'b1;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_msb_first();
        test_mid_word_reset();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
